// File: rtl/mem_pair_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_pair_add_seq
// Brief    : Single-clock sequencer for the two-memory add datapath. On start,
//            reads NUM_PAIRS operand pairs from consecutive source RAM
//            addresses and writes each pair's sum to consecutive result RAM
//            addresses. A one-cycle done pulse marks the end of the run.
// Options  : MEM_PAIR_ADD_SAT_EN - saturate the DW-bit sum instead of
//            carrying into bit DW, and add a sticky sat_flag output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_pair_add_seq #(
  parameter int SRC_AW    = 3,
  parameter int DST_AW    = 3,
  parameter int DW        = 8,
  parameter int RD_LAT    = 1,
  parameter int NUM_PAIRS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              src_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DW-1:0]     src_dout,
  output logic              dst_en,
  output logic              dst_we,
  output logic [DST_AW-1:0] dst_addr,
  output logic [DW:0]       dst_din,
  output logic [DST_AW:0]   pair_cnt
`ifdef MEM_PAIR_ADD_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  // Last value of the wait counter: operand data is valid on this cycle.
  localparam logic [1:0]      C_WAIT_LAST = 2'(RD_LAT - 1);
  // pair_cnt value (before increment) on the final write of a run.
  localparam logic [DST_AW:0] C_LAST_PAIR = (DST_AW + 1)'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_A   = 3'd1,
    S_WAIT_A = 3'd2,
    S_RD_B   = 3'd3,
    S_WAIT_B = 3'd4,
    S_WRITE  = 3'd5,
    S_FIN    = 3'd6
  } state_t;

  state_t              state_q,    state_d;
  logic [SRC_AW-1:0]   src_ptr_q,  src_ptr_d;
  logic [DST_AW-1:0]   dst_ptr_q,  dst_ptr_d;
  logic [DW-1:0]       a_q,        a_d;
  logic [DW-1:0]       b_q,        b_d;
  logic [DST_AW:0]     pair_cnt_q, pair_cnt_d;
  logic [1:0]          wait_cnt_q, wait_cnt_d;
  // Hold registers so dst_addr/dst_din keep their last written value.
  logic [DST_AW-1:0]   dst_addr_q, dst_addr_d;
  logic [DW:0]         dst_din_q,  dst_din_d;

  logic [DW:0]         sum_full;
  logic [DW:0]         wr_data;
  logic                sum_ovf;

  // Full-width sum of the two captured operands; never loses the carry.
  always_comb begin
    sum_full = {1'b0, a_q} + {1'b0, b_q};
    sum_ovf  = sum_full[DW];
  end

`ifdef MEM_PAIR_ADD_SAT_EN
  logic sat_flag_q, sat_flag_d;

  // Clamp to the largest DW-bit value when the carry is set.
  always_comb begin
    wr_data = sum_ovf ? {1'b0, {DW{1'b1}}} : sum_full;
  end

  assign sat_flag = sat_flag_q;
`else
  // Carry is kept in bit DW of the result word.
  always_comb begin
    wr_data = sum_full;
  end
`endif

  // State and datapath registers; async reset returns everything to idle/zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pair_cnt_q <= '0;
      wait_cnt_q <= '0;
      dst_addr_q <= '0;
      dst_din_q  <= '0;
`ifdef MEM_PAIR_ADD_SAT_EN
      sat_flag_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pair_cnt_q <= pair_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      dst_addr_q <= dst_addr_d;
      dst_din_q  <= dst_din_d;
`ifdef MEM_PAIR_ADD_SAT_EN
      sat_flag_q <= sat_flag_d;
`endif
    end
  end

  // Next-state and datapath update: one read per operand, then one write.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    pair_cnt_d = pair_cnt_q;
    wait_cnt_d = wait_cnt_q;
    dst_addr_d = dst_addr_q;
    dst_din_d  = dst_din_q;
`ifdef MEM_PAIR_ADD_SAT_EN
    sat_flag_d = sat_flag_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // start is only looked at here, so a held start cannot restart a run.
        if (start) begin
          src_ptr_d  = '0;
          dst_ptr_d  = '0;
          pair_cnt_d = '0;
`ifdef MEM_PAIR_ADD_SAT_EN
          sat_flag_d = 1'b0;
`endif
          state_d    = S_RD_A;
        end
      end

      S_RD_A: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_A;
      end

      S_WAIT_A: begin
        if (wait_cnt_q == C_WAIT_LAST) begin
          a_d     = src_dout;
          state_d = S_RD_B;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      S_RD_B: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_B;
      end

      S_WAIT_B: begin
        if (wait_cnt_q == C_WAIT_LAST) begin
          b_d     = src_dout;
          state_d = S_WRITE;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      S_WRITE: begin
        dst_addr_d = dst_ptr_q;
        dst_din_d  = wr_data;
        // Pointers wrap silently at the top of their address range.
        src_ptr_d  = src_ptr_q + SRC_AW'(2);
        dst_ptr_d  = dst_ptr_q + DST_AW'(1);
        pair_cnt_d = pair_cnt_q + (DST_AW + 1)'(1);
`ifdef MEM_PAIR_ADD_SAT_EN
        if (sum_ovf) begin
          sat_flag_d = 1'b1;
        end
`endif
        state_d = (pair_cnt_q == C_LAST_PAIR) ? S_FIN : S_RD_A;
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state so reset clears them immediately.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_FIN);
    src_en   = (state_q == S_RD_A) || (state_q == S_RD_B);
    dst_en   = (state_q == S_WRITE);
    dst_we   = (state_q == S_WRITE);
    pair_cnt = pair_cnt_q;

    src_addr = '0;
    if (state_q == S_RD_A) begin
      src_addr = src_ptr_q;
    end else if (state_q == S_RD_B) begin
      src_addr = src_ptr_q + SRC_AW'(1);
    end

    // Outside WRITE the result bus shows the last written address/data.
    if (state_q == S_WRITE) begin
      dst_addr = dst_ptr_q;
      dst_din  = wr_data;
    end else begin
      dst_addr = dst_addr_q;
      dst_din  = dst_din_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_pair_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_pair_add_seq
// Brief    : Self-checking bench for mem_pair_add_seq. Three instances:
//            d0 (RD_LAT=1, 4 pairs), d1 (RD_LAT=2, 4 pairs), d2 (RD_LAT=1,
//            1 pair). Expected writes are queued when a run is started and
//            popped as the DUT writes. Honours MEM_PAIR_ADD_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_pair_add_seq;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [7:0] mem [0:7];

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] exp_addr_q [$];
  logic [8:0] exp_data_q [$];

  // ---------------- instance signals ----------------
  logic       d0_start, d0_busy, d0_done, d0_src_en, d0_dst_en, d0_dst_we;
  logic [2:0] d0_src_addr, d0_dst_addr;
  logic [7:0] d0_src_dout = '0;
  logic [8:0] d0_dst_din;
  logic [3:0] d0_pair_cnt;

  logic       d1_start, d1_busy, d1_done, d1_src_en, d1_dst_en, d1_dst_we;
  logic [2:0] d1_src_addr, d1_dst_addr;
  logic [7:0] d1_src_dout = '0, d1_rd1 = '0;
  logic [8:0] d1_dst_din;
  logic [3:0] d1_pair_cnt;

  logic       d2_start, d2_busy, d2_done, d2_src_en, d2_dst_en, d2_dst_we;
  logic [2:0] d2_src_addr, d2_dst_addr;
  logic [7:0] d2_src_dout = '0;
  logic [8:0] d2_dst_din;
  logic [3:0] d2_pair_cnt;

`ifdef MEM_PAIR_ADD_SAT_EN
  logic d0_sat, d1_sat, d2_sat;
`endif

  mem_pair_add_seq #(.SRC_AW(3), .DST_AW(3), .DW(8), .RD_LAT(1), .NUM_PAIRS(4)) u_d0 (
    .clk(clk), .reset_n(reset_n), .start(d0_start), .busy(d0_busy), .done(d0_done),
    .src_en(d0_src_en), .src_addr(d0_src_addr), .src_dout(d0_src_dout),
    .dst_en(d0_dst_en), .dst_we(d0_dst_we), .dst_addr(d0_dst_addr), .dst_din(d0_dst_din),
    .pair_cnt(d0_pair_cnt)
`ifdef MEM_PAIR_ADD_SAT_EN
    , .sat_flag(d0_sat)
`endif
  );

  mem_pair_add_seq #(.SRC_AW(3), .DST_AW(3), .DW(8), .RD_LAT(2), .NUM_PAIRS(4)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start(d1_start), .busy(d1_busy), .done(d1_done),
    .src_en(d1_src_en), .src_addr(d1_src_addr), .src_dout(d1_src_dout),
    .dst_en(d1_dst_en), .dst_we(d1_dst_we), .dst_addr(d1_dst_addr), .dst_din(d1_dst_din),
    .pair_cnt(d1_pair_cnt)
`ifdef MEM_PAIR_ADD_SAT_EN
    , .sat_flag(d1_sat)
`endif
  );

  mem_pair_add_seq #(.SRC_AW(3), .DST_AW(3), .DW(8), .RD_LAT(1), .NUM_PAIRS(1)) u_d2 (
    .clk(clk), .reset_n(reset_n), .start(d2_start), .busy(d2_busy), .done(d2_done),
    .src_en(d2_src_en), .src_addr(d2_src_addr), .src_dout(d2_src_dout),
    .dst_en(d2_dst_en), .dst_we(d2_dst_we), .dst_addr(d2_dst_addr), .dst_din(d2_dst_din),
    .pair_cnt(d2_pair_cnt)
`ifdef MEM_PAIR_ADD_SAT_EN
    , .sat_flag(d2_sat)
`endif
  );

  // Source RAM models: one-cycle and two-cycle synchronous read.
  always @(posedge clk) begin
    if (d0_src_en) d0_src_dout <= mem[d0_src_addr];
    if (d1_src_en) d1_rd1 <= mem[d1_src_addr];
    d1_src_dout <= d1_rd1;
    if (d2_src_en) d2_src_dout <= mem[d2_src_addr];
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [23:0] snap;
    bit saw_done;
    int done_cyc;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    snap = {d0_busy, d0_done, d0_src_en, d0_src_addr, d0_dst_en, d0_dst_we, d0_dst_addr, d0_dst_din, d0_pair_cnt};
    n_checks++; if (snap !== 24'h0) begin n_fail++; $display("FAIL reset_d0_outputs: got %h expected 000000", snap); end
    snap = {d1_busy, d1_done, d1_src_en, d1_src_addr, d1_dst_en, d1_dst_we, d1_dst_addr, d1_dst_din, d1_pair_cnt};
    n_checks++; if (snap !== 24'h0) begin n_fail++; $display("FAIL reset_d1_outputs: got %h expected 000000", snap); end
    snap = {d2_busy, d2_done, d2_src_en, d2_src_addr, d2_dst_en, d2_dst_we, d2_dst_addr, d2_dst_din, d2_pair_cnt};
    n_checks++; if (snap !== 24'h0) begin n_fail++; $display("FAIL reset_d2_outputs: got %h expected 000000", snap); end
    reset_n = 1'b1;

    // Start a run and pull reset during the first WRITE cycle.
    mem = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    @(posedge clk); #1 d0_start = 1'b1;
    @(posedge clk); #1 d0_start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (d0_dst_we !== 1'b1) begin n_fail++; $display("FAIL midrun_write_active: dst_we=%b expected 1", d0_dst_we); end
    #1 reset_n = 1'b0;
    #1;
    snap = {d0_busy, d0_done, d0_src_en, d0_src_addr, d0_dst_en, d0_dst_we, d0_dst_addr, d0_dst_din, d0_pair_cnt};
    n_checks++; if (snap !== 24'h0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 000000", snap); end
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (d0_done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_no_done: done seen=%b expected 0", saw_done); end
    reset_n = 1'b1;

    // Fresh start after reset: first read of address 0 one cycle later.
    @(posedge clk); #1 d0_start = 1'b1;
    @(posedge clk); #1 d0_start = 1'b0;
    @(negedge clk);
    n_checks++; if ({d0_src_en, d0_src_addr} !== 4'b1_000) begin n_fail++; $display("FAIL restart_first_read: en/addr=%b/%0d expected 1/0", d0_src_en, d0_src_addr); end
    done_cyc = -1;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (d0_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 21) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected 21", done_cyc); end
  endtask

  task automatic test_basic();
    int done_cyc, nwr, nsrc;
    bit busy_gap;
    logic [2:0] ea;
    logic [8:0] ed;
    mem = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_addr_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp_data_q = '{9'h003, 9'h007, 9'h00B, 9'h00F};
    done_cyc = -1; nwr = 0; nsrc = 0; busy_gap = 1'b0;
    @(posedge clk); #1 d0_start = 1'b1;
    @(posedge clk); #1 d0_start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (!d0_busy) busy_gap = 1'b1;
      if (d0_src_en) begin
        n_checks++; if (d0_src_addr !== 3'(nsrc)) begin n_fail++; $display("FAIL basic_src_addr: got %0d expected %0d", d0_src_addr, nsrc); end
        nsrc++;
      end
      if (d0_dst_en && d0_dst_we) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin n_fail++; $display("FAIL basic_extra_write: addr %0d data %h expected none", d0_dst_addr, d0_dst_din); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (d0_dst_addr !== ea || d0_dst_din !== ed) begin n_fail++; $display("FAIL basic_write: got %0d:%h expected %0d:%h", d0_dst_addr, d0_dst_din, ea, ed); end
        end
        n_checks++; if (cyc != 5 * (nwr + 1)) begin n_fail++; $display("FAIL basic_write_cycle: got %0d expected %0d", cyc, 5 * (nwr + 1)); end
        nwr++;
      end
      if (d0_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 21) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 21", done_cyc); end
    n_checks++; if (nwr != 4 || exp_addr_q.size() != 0) begin n_fail++; $display("FAIL basic_write_count: got %0d expected 4", nwr); end
    n_checks++; if (nsrc != 8) begin n_fail++; $display("FAIL basic_read_count: got %0d expected 8", nsrc); end
    n_checks++; if (busy_gap) begin n_fail++; $display("FAIL basic_busy_continuous: gap=%b expected 0", busy_gap); end
    @(negedge clk);
    n_checks++; if ({d0_done, d0_busy} !== 2'b00) begin n_fail++; $display("FAIL basic_after_fin: done/busy=%b expected 00", {d0_done, d0_busy}); end
    n_checks++; if (d0_pair_cnt !== 4'd4) begin n_fail++; $display("FAIL basic_pair_cnt: got %0d expected 4", d0_pair_cnt); end
    n_checks++; if ({d0_dst_addr, d0_dst_din} !== {3'd3, 9'h00F}) begin n_fail++; $display("FAIL basic_dst_hold: got %0d:%h expected 3:00f", d0_dst_addr, d0_dst_din); end
`ifdef MEM_PAIR_ADD_SAT_EN
    n_checks++; if (d0_sat !== 1'b0) begin n_fail++; $display("FAIL basic_sat_flag: got %b expected 0", d0_sat); end
`endif
  endtask

  task automatic test_overflow();
    int done_cyc, nwr;
    logic [2:0] ea;
    logic [8:0] ed;
    mem = '{8'hFF, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h02, 8'h03, 8'h04};
    exp_addr_q = '{3'd0, 3'd1, 3'd2, 3'd3};
`ifdef MEM_PAIR_ADD_SAT_EN
    exp_data_q = '{9'h0FF, 9'h0FF, 9'h003, 9'h007};
`else
    exp_data_q = '{9'h1FE, 9'h100, 9'h003, 9'h007};
`endif
    done_cyc = -1; nwr = 0;
    @(posedge clk); #1 d0_start = 1'b1;
    @(posedge clk); #1 d0_start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (d0_dst_en && d0_dst_we) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin n_fail++; $display("FAIL ovf_extra_write: addr %0d data %h expected none", d0_dst_addr, d0_dst_din); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (d0_dst_addr !== ea || d0_dst_din !== ed) begin n_fail++; $display("FAIL ovf_write: got %0d:%h expected %0d:%h", d0_dst_addr, d0_dst_din, ea, ed); end
        end
        nwr++;
      end
      if (d0_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 21 || nwr != 4) begin n_fail++; $display("FAIL ovf_run: done cycle %0d writes %0d expected 21 and 4", done_cyc, nwr); end
`ifdef MEM_PAIR_ADD_SAT_EN
    @(negedge clk);
    n_checks++; if (d0_sat !== 1'b1) begin n_fail++; $display("FAIL ovf_sat_flag: got %b expected 1", d0_sat); end
`endif
  endtask

  task automatic test_start_held();
    int done_cyc, nwr;
    bit busy_gap;
    logic [2:0] ea;
    logic [8:0] ed;
    mem = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_addr_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp_data_q = '{9'h003, 9'h007, 9'h00B, 9'h00F};
    done_cyc = -1; nwr = 0; busy_gap = 1'b0;
    @(posedge clk); #1 d0_start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
`ifdef MEM_PAIR_ADD_SAT_EN
      if (cyc == 1) begin
        n_checks++; if (d0_sat !== 1'b0) begin n_fail++; $display("FAIL held_sat_cleared: got %b expected 0", d0_sat); end
      end
`endif
      if (!d0_busy) busy_gap = 1'b1;
      if (d0_dst_en && d0_dst_we) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin n_fail++; $display("FAIL held_extra_write: addr %0d data %h expected none", d0_dst_addr, d0_dst_din); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (d0_dst_addr !== ea || d0_dst_din !== ed) begin n_fail++; $display("FAIL held_write: got %0d:%h expected %0d:%h", d0_dst_addr, d0_dst_din, ea, ed); end
        end
        nwr++;
      end
      if (d0_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 21 || nwr != 4) begin n_fail++; $display("FAIL held_first_run: done cycle %0d writes %0d expected 21 and 4", done_cyc, nwr); end
    n_checks++; if (busy_gap) begin n_fail++; $display("FAIL held_busy_continuous: gap=%b expected 0", busy_gap); end
    @(negedge clk);
    n_checks++; if ({d0_busy, d0_src_en} !== 2'b00) begin n_fail++; $display("FAIL held_idle_gap: busy/src_en=%b expected 00", {d0_busy, d0_src_en}); end
    @(negedge clk);
    n_checks++; if ({d0_busy, d0_src_en, d0_src_addr, d0_pair_cnt} !== {1'b1, 1'b1, 3'd0, 4'd0}) begin n_fail++; $display("FAIL held_second_start: busy/en/addr/cnt=%b/%b/%0d/%0d expected 1/1/0/0", d0_busy, d0_src_en, d0_src_addr, d0_pair_cnt); end
    d0_start = 1'b0;
    done_cyc = -1;
    for (int cyc = 2; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (d0_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 21) begin n_fail++; $display("FAIL held_second_run_done: got %0d expected 21", done_cyc); end
  endtask

  task automatic test_rd_lat2();
    int done_cyc, nwr;
    logic [2:0] ea;
    logic [8:0] ed;
    mem = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_addr_q = '{3'd0, 3'd1, 3'd2, 3'd3};
    exp_data_q = '{9'h003, 9'h007, 9'h00B, 9'h00F};
    done_cyc = -1; nwr = 0;
    @(posedge clk); #1 d1_start = 1'b1;
    @(posedge clk); #1 d1_start = 1'b0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (d1_dst_en && d1_dst_we) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin n_fail++; $display("FAIL lat2_extra_write: addr %0d data %h expected none", d1_dst_addr, d1_dst_din); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (d1_dst_addr !== ea || d1_dst_din !== ed) begin n_fail++; $display("FAIL lat2_write: got %0d:%h expected %0d:%h", d1_dst_addr, d1_dst_din, ea, ed); end
        end
        n_checks++; if (cyc != 7 * (nwr + 1)) begin n_fail++; $display("FAIL lat2_write_cycle: got %0d expected %0d", cyc, 7 * (nwr + 1)); end
        nwr++;
      end
      if (d1_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 29 || nwr != 4) begin n_fail++; $display("FAIL lat2_run: done cycle %0d writes %0d expected 29 and 4", done_cyc, nwr); end
    n_checks++; if (d1_pair_cnt !== 4'd4) begin n_fail++; $display("FAIL lat2_pair_cnt: got %0d expected 4", d1_pair_cnt); end
  endtask

  task automatic test_single_pair();
    int done_cyc, nwr, nsrc;
    bit late_read;
    logic [2:0] ea;
    logic [8:0] ed;
    mem = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    exp_addr_q = '{3'd0};
    exp_data_q = '{9'h003};
    done_cyc = -1; nwr = 0; nsrc = 0; late_read = 1'b0;
    @(posedge clk); #1 d2_start = 1'b1;
    @(posedge clk); #1 d2_start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (d2_src_en) nsrc++;
      if (d2_dst_en && d2_dst_we) begin
        n_checks++;
        if (exp_addr_q.size() == 0) begin n_fail++; $display("FAIL single_extra_write: addr %0d data %h expected none", d2_dst_addr, d2_dst_din); end
        else begin
          ea = exp_addr_q.pop_front(); ed = exp_data_q.pop_front();
          if (d2_dst_addr !== ea || d2_dst_din !== ed || cyc != 5) begin n_fail++; $display("FAIL single_write: got %0d:%h at cycle %0d expected %0d:%h at cycle 5", d2_dst_addr, d2_dst_din, cyc, ea, ed); end
        end
        nwr++;
      end
      if (d2_done) begin done_cyc = cyc; break; end
    end
    n_checks++; if (done_cyc != 6 || nwr != 1) begin n_fail++; $display("FAIL single_run: done cycle %0d writes %0d expected 6 and 1", done_cyc, nwr); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (d2_src_en || d2_busy) late_read = 1'b1;
    end
    n_checks++; if (nsrc != 2 || late_read) begin n_fail++; $display("FAIL single_reads: reads %0d late activity %b expected 2 and 0", nsrc, late_read); end
    n_checks++; if (d2_pair_cnt !== 4'd1) begin n_fail++; $display("FAIL single_pair_cnt: got %0d expected 1", d2_pair_cnt); end
  endtask

  initial begin
    d0_start = 1'b0;
    d1_start = 1'b0;
    d2_start = 1'b0;
    reset_n  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_start_held();
    test_rd_lat2();
    test_single_pair();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
